// File: rtl/drum_lane_painter_pkg.sv
// Shared types and helpers for the drum lane painter: FSM state codes,
// multi-pad policy selectors and a one-hot test.
package drum_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARMED    = 3'd1,
    DEBOUNCE = 3'd2,
    LANE     = 3'd3,
    RELEASE  = 3'd4,
    STATIC   = 3'd5
  } state_e;

  localparam int MULTI_REJECT = 0;
  localparam int MULTI_LOWEST = 1;

  // Callers zero-extend narrower pad vectors to 16 bits.
  function automatic logic is_onehot(input logic [15:0] v);
    return ($countones(v) == 1);
  endfunction

endpackage

// File: rtl/drum_lane_painter_if.sv
// Pad/request inputs and paint/hit outputs of the drum lane painter.
// Level inputs, no handshake: the painter samples every input on each clk edge.
interface drum_lane_painter_if #(
  parameter int N_LANES = 5,
  parameter int CNT_W   = 8,
  parameter int IDX_W   = $clog2(N_LANES)
);
  logic               start;
  logic               stop;
  logic               static_req;
  logic [N_LANES-1:0] pad;
  logic               paint_static;
  logic [N_LANES-1:0] paint_lane;
  logic               hit_pulse;
  logic [IDX_W-1:0]   hit_lane;
  logic [CNT_W-1:0]   hit_count;

  modport master (
    output start, stop, static_req, pad,
    input  paint_static, paint_lane, hit_pulse, hit_lane, hit_count
  );

  modport slave (
    input  start, stop, static_req, pad,
    output paint_static, paint_lane, hit_pulse, hit_lane, hit_count
  );
endinterface

// File: rtl/drum_lane_painter_pad_encoder.sv
// Combinational pad qualifier: decides whether the pad pattern is a hit
// candidate and yields its one-hot pattern and lane index.
module drum_pad_encoder
  import drum_pkg::*;
#(
  parameter int N_LANES    = 5,
  parameter int MULTI_MODE = MULTI_REJECT,
  parameter int IDX_W      = $clog2(N_LANES)
) (
  input  logic [N_LANES-1:0] pad,
  output logic               valid,
  output logic [N_LANES-1:0] cand,
  output logic [IDX_W-1:0]   idx
);

  always_comb begin
    valid = 1'b0;
    cand  = '0;
    idx   = '0;
    if (MULTI_MODE == MULTI_LOWEST) begin
      // Walk downwards so the lowest set bit is the last one written.
      for (int i = N_LANES - 1; i >= 0; i--) begin
        if (pad[i]) begin
          valid   = 1'b1;
          cand    = '0;
          cand[i] = 1'b1;
          idx     = IDX_W'(i);
        end
      end
    end else if (is_onehot(16'(pad))) begin
      valid = 1'b1;
      cand  = pad;
      for (int i = 0; i < N_LANES; i++) begin
        if (pad[i]) idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/drum_lane_painter.sv
// Drum lane paint controller: debounced pad hits light one lane, with
// stuck-pad timeout, release-before-rearm, a static band and a hit counter.
module drum_lane_painter
  import drum_pkg::*;
#(
  parameter int N_LANES      = 5,
  parameter int DEBOUNCE_CYC = 4,
  parameter int MAX_HOLD_CYC = 1000000,
  parameter int MULTI_MODE   = 0,
  parameter int CNT_W        = 8
) (
  input  logic              clk,
  input  logic              reset,
  drum_lane_painter_if.slave bus,
  output logic [2:0]        dbg_state
);

  localparam int IDX_W = $clog2(N_LANES);
  localparam int DW    = $clog2(DEBOUNCE_CYC + 1);
  localparam int HW    = $clog2(MAX_HOLD_CYC + 1);

  localparam logic [2:0] S_IDLE     = IDLE;
  localparam logic [2:0] S_ARMED    = ARMED;
  localparam logic [2:0] S_DEBOUNCE = DEBOUNCE;
  localparam logic [2:0] S_LANE     = LANE;
  localparam logic [2:0] S_RELEASE  = RELEASE;
  localparam logic [2:0] S_STATIC   = STATIC;

  logic [2:0]         state;
  logic [N_LANES-1:0] cand_r;
  logic [DW-1:0]      dcnt;
  logic [HW-1:0]      hcnt;
  logic [IDX_W-1:0]   hit_lane_r;
  logic [CNT_W-1:0]   hit_count_r;

  logic               enc_valid;
  logic [N_LANES-1:0] enc_cand;
  logic [IDX_W-1:0]   enc_idx;
  logic [N_LANES-1:0] sel;
  logic               take_hit;

  drum_pad_encoder #(
    .N_LANES   (N_LANES),
    .MULTI_MODE(MULTI_MODE),
    .IDX_W     (IDX_W)
  ) u_enc (
    .pad  (bus.pad),
    .valid(enc_valid),
    .cand (enc_cand),
    .idx  (enc_idx)
  );

  // In DEBOUNCE the current encoder index equals the latched candidate's,
  // so enc_idx is valid for every lane-entry path.
  always_comb begin
    sel      = enc_valid ? enc_cand : '0;
    take_hit = 1'b0;
    if (!bus.stop) begin
      if (state == S_ARMED && enc_valid && DEBOUNCE_CYC == 1)
        take_hit = 1'b1;
      if (state == S_DEBOUNCE && sel == cand_r && (dcnt + DW'(1)) == DW'(DEBOUNCE_CYC))
        take_hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      cand_r      <= '0;
      dcnt        <= '0;
      hcnt        <= '0;
      hit_lane_r  <= '0;
      hit_count_r <= '0;
    end else if (bus.stop && state != S_IDLE) begin
      state <= S_IDLE;
    end else if (take_hit) begin
      state      <= S_LANE;
      cand_r     <= sel;
      dcnt       <= '0;
      hcnt       <= HW'(1);
      hit_lane_r <= enc_idx;
      if (hit_count_r != {CNT_W{1'b1}}) hit_count_r <= hit_count_r + CNT_W'(1);
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          state       <= S_ARMED;
          hit_count_r <= '0;
        end
        S_ARMED: begin
          if (enc_valid) begin
            state  <= S_DEBOUNCE;
            cand_r <= sel;
            dcnt   <= DW'(1);
          end else if (bus.static_req) begin
            state <= S_STATIC;
          end
        end
        S_DEBOUNCE: begin
          if (sel == cand_r) begin
            dcnt <= dcnt + DW'(1);
          end else begin
            state <= S_ARMED;
            dcnt  <= '0;
          end
        end
        S_LANE: begin
          if (bus.pad != cand_r || hcnt == HW'(MAX_HOLD_CYC)) state <= S_RELEASE;
          else hcnt <= hcnt + HW'(1);
        end
        S_RELEASE: if (bus.pad == '0) state <= S_ARMED;
        S_STATIC:  if (!bus.static_req) state <= S_ARMED;
        default:   state <= S_IDLE;
      endcase
    end
  end

  assign bus.paint_static = (state == S_STATIC);
  assign bus.paint_lane   = (state == S_LANE) ? cand_r : '0;
  assign bus.hit_pulse    = (state == S_LANE) && (hcnt == HW'(1));
  assign bus.hit_lane     = hit_lane_r;
  assign bus.hit_count    = hit_count_r;
  assign dbg_state        = state;

endmodule

// File: tb/tb_drum_lane_painter.sv
// Bench for drum_lane_painter: two configurations share one stimulus stream
// and are checked every cycle against a behavioural game model.
module tb_drum_lane_painter;

  localparam int N = 5;

  logic clk = 1'b0;
  logic reset, start, stop, static_req;
  logic [N-1:0] pad;
  logic [2:0] dbg_a, dbg_b;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  // a: strict one-hot, 4-cycle debounce, 2-bit counter.
  // b: lowest-pad-wins, no debounce, 8-bit counter.
  drum_lane_painter_if #(.N_LANES(N), .CNT_W(2)) if_a ();
  drum_lane_painter_if #(.N_LANES(N), .CNT_W(8)) if_b ();

  assign if_a.start = start;  assign if_a.stop = stop;
  assign if_a.static_req = static_req;  assign if_a.pad = pad;
  assign if_b.start = start;  assign if_b.stop = stop;
  assign if_b.static_req = static_req;  assign if_b.pad = pad;

  drum_lane_painter #(.N_LANES(N), .DEBOUNCE_CYC(4), .MAX_HOLD_CYC(8),
                      .MULTI_MODE(0), .CNT_W(2)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a), .dbg_state(dbg_a));

  drum_lane_painter #(.N_LANES(N), .DEBOUNCE_CYC(1), .MAX_HOLD_CYC(8),
                      .MULTI_MODE(1), .CNT_W(8)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b), .dbg_state(dbg_b));

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_ARMED = 1, M_DEB = 2, M_LANE = 3, M_REL = 4, M_STATIC = 5;
  int c_deb[2]   = '{4, 1};
  int c_max[2]   = '{8, 8};
  int c_multi[2] = '{0, 1};
  int c_cmax[2]  = '{3, 255};

  int m_mode[2], m_cand[2], m_run[2], m_hold[2], m_lane[2], m_count[2];

  // Pattern a pad vector contributes under the given policy (0 = nothing usable).
  function automatic int pick(input int p, input int multi);
    if (multi == 0) return ($countones(p) == 1) ? p : 0;
    for (int i = 0; i < N; i++) if (p[i]) return (1 << i);
    return 0;
  endfunction

  function automatic int lane_of(input int p);
    for (int i = 0; i < N; i++) if (p[i]) return i;
    return 0;
  endfunction

  task automatic model_hit(input int k);
    m_mode[k] = M_LANE;
    m_lane[k] = lane_of(m_cand[k]);
    m_hold[k] = 1;
    if (m_count[k] < c_cmax[k]) m_count[k]++;
  endtask

  task automatic model_step(input int k);
    int p, s;
    p = int'(pad);
    s = pick(p, c_multi[k]);
    if (!reset) begin
      m_mode[k] = M_IDLE; m_cand[k] = 0; m_run[k] = 0;
      m_hold[k] = 0; m_lane[k] = 0; m_count[k] = 0;
    end else if (stop && m_mode[k] != M_IDLE) begin
      m_mode[k] = M_IDLE;
    end else begin
      case (m_mode[k])
        M_IDLE: if (start) begin m_mode[k] = M_ARMED; m_count[k] = 0; end
        M_ARMED: begin
          if (s != 0) begin
            m_cand[k] = s;
            if (c_deb[k] == 1) model_hit(k);
            else begin m_mode[k] = M_DEB; m_run[k] = 1; end
          end else if (static_req) m_mode[k] = M_STATIC;
        end
        M_DEB: begin
          if (s == m_cand[k]) begin
            m_run[k]++;
            if (m_run[k] == c_deb[k]) model_hit(k);
          end else begin
            m_mode[k] = M_ARMED; m_run[k] = 0;
          end
        end
        M_LANE: begin
          if (p != m_cand[k] || m_hold[k] == c_max[k]) m_mode[k] = M_REL;
          else m_hold[k]++;
        end
        M_REL:    if (p == 0) m_mode[k] = M_ARMED;
        M_STATIC: if (!static_req) m_mode[k] = M_ARMED;
        default:  m_mode[k] = M_IDLE;
      endcase
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("a.paint_static", 32'(if_a.paint_static), 32'(m_mode[0] == M_STATIC));
    check("a.paint_lane",   32'(if_a.paint_lane),   (m_mode[0] == M_LANE) ? m_cand[0] : 0);
    check("a.hit_pulse",    32'(if_a.hit_pulse),    32'(m_mode[0] == M_LANE && m_hold[0] == 1));
    check("a.hit_lane",     32'(if_a.hit_lane),     m_lane[0]);
    check("a.hit_count",    32'(if_a.hit_count),    m_count[0]);
    check("b.paint_static", 32'(if_b.paint_static), 32'(m_mode[1] == M_STATIC));
    check("b.paint_lane",   32'(if_b.paint_lane),   (m_mode[1] == M_LANE) ? m_cand[1] : 0);
    check("b.hit_pulse",    32'(if_b.hit_pulse),    32'(m_mode[1] == M_LANE && m_hold[1] == 1));
    check("b.hit_lane",     32'(if_b.hit_lane),     m_lane[1]);
    check("b.hit_count",    32'(if_b.hit_count),    m_count[1]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      compare_all();
    end
  endtask

  task automatic press(input logic [N-1:0] p, input int hold, input int gap);
    pad = p;  cycle(hold);
    pad = '0; cycle(gap);
  endtask

  task automatic new_game();
    stop = 1'b1;  cycle(1);
    stop = 1'b0;  start = 1'b1; cycle(1);
    start = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; start = 1'b0; stop = 1'b0; static_req = 1'b0; pad = '0;
    cycle(2);
    reset = 1'b1; cycle(1);
    start = 1'b1; cycle(1);
    start = 1'b0; cycle(1);

    // First hit: lane appears on the 4th sampling edge for the debounced DUT.
    pad = 5'b00100; cycle(4);
    check("first.paint_lane", 32'(if_a.paint_lane), 32'h04);
    check("first.hit_pulse",  32'(if_a.hit_pulse),  32'h1);
    check("first.hit_lane",   32'(if_a.hit_lane),   32'h2);
    check("first.hit_count",  32'(if_a.hit_count),  32'h1);
    cycle(1);
    check("first.pulse_once", 32'(if_a.hit_pulse),  32'h0);
    pad = '0; cycle(3);

    // Bounce then a clean press.
    press(5'b00010, 2, 1);
    press(5'b00010, 4, 3);

    // Two pads together: rejected by a, lowest pad wins in b.
    pad = 5'b01010; cycle(1);
    check("multi.b_lane", 32'(if_b.hit_lane), 32'h1);
    cycle(4);
    check("multi.a_nopaint", 32'(if_a.paint_lane), 32'h0);
    pad = '0; cycle(3);

    // Stuck pad: timeout after 8 lane cycles, rearm only after release.
    press(5'b10000, 20, 3);

    // Static band with pads pressed meanwhile.
    static_req = 1'b1; cycle(3);
    check("static.a", 32'(if_a.paint_static), 32'h1);
    press(5'b00001, 6, 1);
    static_req = 1'b0; cycle(3);

    // Saturation: five hits in a fresh game.
    new_game();
    for (int h = 0; h < 5; h++) press(N'(1 << (h % N)), 5, 2);
    check("sat.a_count", 32'(if_a.hit_count), 32'h3);
    check("sat.b_count", 32'(if_b.hit_count), 32'h5);

    // Stop while painting.
    pad = 5'b00001; cycle(5);
    stop = 1'b1; cycle(1);
    stop = 1'b0;
    check("stop.a_paint", 32'(if_a.paint_lane), 32'h0);
    pad = '0; cycle(2);

    // Reset in the middle of a debounce.
    new_game();
    pad = 5'b01000; cycle(2);
    reset = 1'b0; cycle(1);
    check("rst.a_count", 32'(if_a.hit_count), 32'h0);
    reset = 1'b1; pad = '0; cycle(1);
    start = 1'b1; cycle(1);
    start = 1'b0;

    // Randomized play.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) != 0);
      start = ($urandom_range(0, 9) == 0);
      stop  = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 19) == 0) static_req = ~static_req;
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 3))
          0: pad = '0;
          1: pad = N'(1 << $urandom_range(0, N - 1));
          2: pad = N'(1 << $urandom_range(0, N - 1));
          default: pad = N'($urandom_range(0, (1 << N) - 1));
        endcase
      end
      cycle(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
